mdu_iter: RTL

Parametrised iterative multiply/divide unit with HI/LO result registers, sitting beside the single-cycle ALU in the MIPS datapath. It executes MULT, MULTU, DIV and DIVU over WIDTH cycles, holds results in HI/LO for MFHI/MFLO, and supports MTHI/MTLO writes plus a cancel for flushes. It generalises the ALU to multi-cycle operations with a start/busy/done handshake and explicit divide-by-zero reporting.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_step.sv | 40 ++++
 rtl/mdu_iter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

    // Divide ops have op[1] set.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Signed ops have op[0] clear.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// The accumulator is {upper, lower}:
//   multiply: upper = partial sum, lower = remaining multiplier bits
//   divide:   upper = partial remainder, lower = dividend bits / quotient bits
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 i_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opb,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;

    assign w_hi   = i_acc[2*WIDTH-1:WIDTH];
    assign w_lo   = i_acc[WIDTH-1:0];
    // Add the multiplicand when the current multiplier bit is set; keep the carry.
    assign w_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_opb} : {(WIDTH+1){1'b0}});
    // Partial remainder is always below the divisor, so bit WIDTH of the
    // difference is a clean "trial went negative" flag.
    assign w_diff = {w_hi, w_lo[WIDTH-1]} - {1'b0, i_opb};

    // Select shift-add or restoring trial-subtract-shift.
    always_comb begin
        o_acc = '0;
        if (i_div) begin
            if (w_diff[WIDTH])
                o_acc = {w_hi[WIDTH-2:0], w_lo, 1'b0};
            else
                o_acc = {w_diff[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1};
        end else begin
            o_acc = {w_sum, w_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, MTHI/MTLO writes
// and a cancel for pipeline flushes. One iteration per cycle, then a sign
// fix-up cycle that writes HI/LO and pulses done.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_srca,
    input  logic [WIDTH-1:0] i_srcb,
    input  logic             i_cancel,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t               r_state, w_next;
    logic [CW-1:0]        r_cnt;
    logic [1:0]           r_op;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opb;
    logic [WIDTH-1:0]     r_srca;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [WIDTH-1:0]     r_hi, r_lo;
    logic                 r_done, r_div_by_zero;

    logic                 w_a_neg, w_b_neg;
    logic [WIDTH-1:0]     w_a_mag, w_b_mag;
    logic [2*WIDTH-1:0]   w_step;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo, w_rem;
    logic                 w_dbz;
    logic [WIDTH-1:0]     w_fix_hi, w_fix_lo;

    // Operand magnitudes; unsigned ops never see a "negative" operand.
    assign w_a_neg = op_is_signed(i_op) & i_srca[WIDTH-1];
    assign w_b_neg = op_is_signed(i_op) & i_srcb[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~i_srca + 1'b1) : i_srca;
    assign w_b_mag = w_b_neg ? (~i_srcb + 1'b1) : i_srcb;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_div (op_is_div(r_op)),
        .i_acc (r_acc),
        .i_opb (r_opb),
        .o_acc (w_step)
    );

    // Sign fix-up and divide-by-zero override for the result edge.
    always_comb begin
        w_prod   = r_neg_q ? (~r_acc + 1'b1) : r_acc;
        w_quo    = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
        w_rem    = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
        w_dbz    = op_is_div(r_op) && (r_opb == '0);
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (op_is_div(r_op)) begin
            if (w_dbz) begin
                w_fix_hi = r_srca;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = w_rem;
                w_fix_lo = w_quo;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic; cancel aborts from any busy state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (i_start) w_next = RUN;
            RUN: begin
                if (i_cancel)          w_next = IDLE;
                else if (r_cnt == '0)  w_next = FIX;
            end
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result write and MTHI/MTLO.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt         <= '0;
            r_op          <= OP_MULT;
            r_acc         <= '0;
            r_opb         <= '0;
            r_srca        <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_op    <= i_op;
                        r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_opb   <= w_b_mag;
                        r_srca  <= i_srca;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= CW'(WIDTH - 1);
                    end else begin
                        if (i_wr_hi) r_hi <= i_wdata;
                        if (i_wr_lo) r_lo <= i_wdata;
                    end
                end
                RUN: begin
                    if (!i_cancel) begin
                        r_acc <= w_step;
                        if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                    end
                end
                FIX: begin
                    if (!i_cancel) begin
                        r_hi          <= w_fix_hi;
                        r_lo          <= w_fix_lo;
                        r_done        <= 1'b1;
                        r_div_by_zero <= w_dbz;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy        = (r_state != IDLE);
    assign o_done        = r_done;
    assign o_div_by_zero = r_div_by_zero;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

endmodule
